pdm_port_rx: RTL and testbench
==============================

Name: pdm_port_rx

Overview:
- Downstream consumer of one PDM output port.
- Accepts the newdata_len / proceed / data byte-stream handshake, buffers each packet in a byte FIFO, and re-presents it as a valid/ready stream with start-of-packet and end-of-packet markers.
- One instance per PDM output port (4 per design); it feeds the port checker/egress logic.

Parameters:
- FIFO_DEPTH, 32, byte entries in the buffer; power of 2, minimum 32 (one max-length packet).
- DATA_DLY, 2, clk edges from the edge sampling proceed=1 to the edge sampling the first payload byte; range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_b  in  1  reset, asynchronous, active-high.
- newdata_len  in  5  packet length announce; nonzero for one cycle = new packet of that many bytes.
- proceed  out  1  one-cycle grant; upstream starts sending DATA_DLY edges later.
- data_in  in  8  payload byte, one per cycle after grant.
- out_valid  out  1  out_data/out_sop/out_eop valid.
- out_ready  in  1  consumer accepts the byte when out_valid and out_ready are both 1.
- out_data  out  8  buffered payload byte.
- out_sop  out  1  first byte of a packet.
- out_eop  out  1  last byte of a packet.
- busy  out  1  high in any state except IDLE.
- len_err  out  1  one-cycle pulse on a protocol violation.
- pkt_cnt  out  16  packets fully received (see Optional Feature).

Behaviour:
- Reset (async, rst_b=1): state IDLE; FIFO emptied. proceed, out_valid, out_sop, out_eop, busy, len_err, pkt_cnt all 0; out_data 0.
- Reset mid-packet: the partial packet and all buffered bytes are discarded.
- FSM states and transitions:
  - IDLE: on an edge with newdata_len!=0, latch len and go to WAIT_ROOM.
  - WAIT_ROOM: when free entries >= len, go to GRANT. Otherwise hold; there is no timeout.
  - GRANT: proceed=1 for exactly this one cycle. Then go to GAP, or straight to RECV if DATA_DLY=1.
  - GAP: count DATA_DLY-1 edges, then go to RECV.
  - RECV: sample data_in on each of len consecutive edges and push {byte, sop=(first), eop=(last)}. On the edge capturing the last byte, go to IDLE and increment pkt_cnt (wraps at 0xFFFF).
- Free-space check: uses the FIFO count as of that cycle, including a same-cycle pop. This guarantees RECV never sees a full FIFO, so there is no overflow path.
- Length handling: a len=1 packet gives one entry with sop=eop=1. The length width is 5 bits, so the maximum is 31 bytes.
- len_err pulses (and newdata_len is ignored) when newdata_len!=0 is sampled in any state other than IDLE.
- busy = (state != IDLE).
- Output side: first-word fall-through. out_valid=1 whenever the FIFO is non-empty, and out_data/out_sop/out_eop show the head entry combinationally from storage. Holding out_ready=0 stalls the output with no data loss.
- Simultaneous push and pop in one cycle: the count is unchanged, and pointers wrap modulo FIFO_DEPTH.
- Back-to-back packets: a new newdata_len is accepted on the first IDLE cycle after the last byte edge.

Optional Feature:
- Macro: PDM_PORT_RX_STATS_EN.
- With the macro defined: pkt_cnt counts as described above.
- Without it: pkt_cnt is tied to 0 and the counter is not built. All other behaviour is identical.

Decomposition:
- Shared package pdm_pkg holds:
  - typedef pdm_byte_t (logic [7:0]);
  - typedef pdm_len_t (logic [4:0]);
  - PDM_MAX_LEN = 31;
  - PDM_NUM_PORTS = 4;
  - enum rx_state_t {IDLE, WAIT_ROOM, GRANT, GAP, RECV}.
- One sub-module, pdm_byte_fifo: parameterised width (10 = byte+sop+eop) and depth, with push/pop/count/empty. It uses async reset, active-high.

Test Plan:
- Single packet: newdata_len=3, then bytes 0xA1, 0xA2, 0xA3 DATA_DLY=2 edges after proceed, with out_ready=1. Expect:
  - proceed high for exactly 1 cycle, 1 cycle after the announce;
  - output A1(sop), A2, A3(eop);
  - pkt_cnt=1.
- Backpressure/full: hold out_ready=0, send a 31-byte packet, then announce len=5. Expect:
  - proceed for the second packet withheld (busy=1, WAIT_ROOM);
  - raise out_ready; proceed fires once free>=5;
  - 36 bytes out in order with correct sop/eop.
- Protocol error: newdata_len=4 during RECV of a 6-byte packet. Expect:
  - len_err one-cycle pulse;
  - the 6-byte packet is intact and the 4-byte packet is never granted.
- Minimum length and back-to-back: five consecutive len=1 packets (0x10..0x14), each announced on the first IDLE cycle. Expect five entries, each with sop=eop=1, and pkt_cnt=5.
- Reset mid-packet: assert rst_b after 2 of 8 bytes. Expect:
  - out_valid=0, proceed=0, busy=0, pkt_cnt=0 asynchronously;
  - a subsequent len=2 packet 0x55, 0x66 is delivered cleanly.
- Macro off (PDM_PORT_RX_STATS_EN undefined): rerun the back-to-back test. Expect pkt_cnt stays 0 and data is identical.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared PDM types and constants used by the per-port receive logic.
package pdm_pkg;

  typedef logic [7:0] pdm_byte_t;
  typedef logic [4:0] pdm_len_t;

  localparam int PDM_MAX_LEN   = 31;
  localparam int PDM_NUM_PORTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROOM,
    GRANT,
    GAP,
    RECV
  } rx_state_t;

  // One buffered byte with its packet markers.
  typedef struct packed {
    logic      sop;
    logic      eop;
    pdm_byte_t data;
  } rx_entry_t;

endpackage

// File: rtl/pdm_port_rx_if.sv
// PDM output-port link: upstream byte handshake plus the re-framed valid/ready stream.
interface pdm_port_rx_if;
  import pdm_pkg::*;

  pdm_len_t  newdata_len;
  logic      proceed;
  pdm_byte_t data_in;
  logic      out_valid;
  logic      out_ready;
  pdm_byte_t out_data;
  logic      out_sop;
  logic      out_eop;

  modport master (
    output newdata_len, data_in, out_ready,
    input  proceed, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  newdata_len, data_in, out_ready,
    output proceed, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/pdm_byte_fifo.sv
// First-word fall-through FIFO; head entry is read combinationally from storage.
module pdm_byte_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pdm_port_rx.sv
// Receives one PDM output port's packets into a byte FIFO and re-emits them as a framed stream.
// Define PDM_PORT_RX_STATS_EN to build the received-packet counter (pkt_cnt); otherwise it reads 0.
module pdm_port_rx
  import pdm_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int DATA_DLY   = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  pdm_port_rx_if.slave        bus,
  output logic                busy,
  output logic                len_err,
  output logic [15:0]         pkt_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = FIFO_DEPTH[CW-1:0];
  localparam logic [1:0]    GAP_INIT = (DATA_DLY > 1) ? 2'(DATA_DLY - 2) : 2'd0;

  rx_state_t     state, state_d;
  pdm_len_t      len_q, len_d;
  pdm_len_t      idx_q, idx_d;
  logic [1:0]    gap_q, gap_d;
  logic          push, pop, empty, last;
  logic [CW-1:0] count, free;
  rx_entry_t     wdata, head;

  pdm_byte_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = empty ? '0 : head.data;
  assign bus.out_sop   = !empty && head.sop;
  assign bus.out_eop   = !empty && head.eop;
  assign busy          = (state != IDLE);

  // A pop in this same cycle already counts as room, so RECV can never meet a full FIFO.
  assign free  = FULL_CNT - count + CW'(pop);
  assign last  = (idx_q == len_q - pdm_len_t'(1));
  assign wdata = '{sop: (idx_q == '0), eop: last, data: bus.data_in};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state;
    len_d       = len_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    push        = 1'b0;
    bus.proceed = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.newdata_len != '0) begin
          len_d   = bus.newdata_len;
          state_d = WAIT_ROOM;
        end
      end
      WAIT_ROOM: begin
        if (free >= CW'(len_q)) state_d = GRANT;
      end
      GRANT: begin
        bus.proceed = 1'b1;
        idx_d       = '0;
        gap_d       = GAP_INIT;
        state_d     = (DATA_DLY == 1) ? RECV : GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = RECV;
        else             gap_d   = gap_q - 2'd1;
      end
      RECV: begin
        push  = 1'b1;
        idx_d = idx_q + pdm_len_t'(1);
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state   <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      len_err <= 1'b0;
    end else begin
      state   <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      len_err <= (state != IDLE) && (bus.newdata_len != '0);
    end
  end

`ifdef PDM_PORT_RX_STATS_EN
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)                      pkt_cnt <= '0;
    else if (state == RECV && last) pkt_cnt <= pkt_cnt + 16'd1;
  end
`else
  assign pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_pdm_port_rx.sv
// Directed bench for pdm_port_rx: packet-level model queue checked on every accepted output beat.
module tb_pdm_port_rx;
  import pdm_pkg::*;

  localparam int DEPTH = 32;
  localparam int DLY   = 2;
`ifdef PDM_PORT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        busy, len_err;
  logic [15:0] pkt_cnt;

  pdm_port_rx_if bus ();

  pdm_port_rx #(.FIFO_DEPTH(DEPTH), .DATA_DLY(DLY)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .bus     (bus.slave),
    .busy    (busy),
    .len_err (len_err),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Model: expected beats as {sop, eop, data}, plus packets completed since reset.
  logic [9:0] exp_q [$];
  logic [9:0] exp_beat;
  logic [7:0] pkt [32];
  int model_pkts = 0;
  int n_out = 0, n_lenerr = 0;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_b) begin
      check("pkt_cnt", pkt_cnt, STATS ? model_pkts : 0);
      if (len_err) n_lenerr++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_beat: got %0h expected no beat at %0t",
                   {bus.out_sop, bus.out_eop, bus.out_data}, $time);
        end else begin
          exp_beat = exp_q.pop_front();
          check("out_beat", {bus.out_sop, bus.out_eop, bus.out_data}, exp_beat);
          n_out++;
        end
      end
    end
  end

  // All driver tasks start and end #1 after a rising edge.
  task automatic announce(input int len);
    bus.newdata_len = 5'(len);
    @(posedge clk); #1;
    bus.newdata_len = '0;
  endtask

  task automatic wait_grant(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.proceed !== 1'b1 && waited < budget);
    check("grant_seen", bus.proceed, 1);
    @(posedge clk); #1;
    check("proceed_one_cycle", bus.proceed, 0);
    repeat (DLY - 1) begin @(posedge clk); #1; end
  endtask

  task automatic send_payload(input int len, input int err_at);
    for (int i = 0; i < len; i++) begin
      bus.data_in     = pkt[i];
      bus.newdata_len = (i == err_at) ? 5'd4 : 5'd0;
      exp_q.push_back({i == 0, i == len - 1, pkt[i]});
      @(posedge clk); #1;
      bus.newdata_len = '0;
      if (i == err_at) check("len_err_pulse", len_err, 1);
      if (err_at >= 0 && i == err_at + 1) check("len_err_clear", len_err, 0);
    end
    model_pkts++;
    bus.data_in = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    check("drained", exp_q.size(), 0);
    @(negedge clk);
    check("valid_after_drain", bus.out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    exp_q.delete();
    model_pkts = 0;
    @(posedge clk); #3;
    rst_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base, granted;
    bus.newdata_len = '0;
    bus.data_in     = '0;
    bus.out_ready   = 1'b0;

    // Reset values
    #2;
    check("rst_valid", bus.out_valid, 0);
    check("rst_proceed", bus.proceed, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_data", bus.out_data, 0);
    @(posedge clk); #3;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Single packet A1 A2 A3
    pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
    base = n_out;
    announce(3);
    check("t1_busy", busy, 1);
    wait_grant(20, w);
    check("t1_grant_latency", w, 2);
    send_payload(3, -1);
    check("t1_head_valid", bus.out_valid, 1);
    check("t1_head", {bus.out_sop, bus.out_eop, bus.out_data}, 10'h2A1);
    check("t1_pkt_cnt", pkt_cnt, STATS ? 1 : 0);
    drain(50);
    check("t1_beats", n_out - base, 3);

    // Backpressure: 31 bytes buffered, then a 5-byte packet must wait for room
    bus.out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 31; i++) pkt[i] = 8'(8'h40 + i);
    announce(31);
    wait_grant(20, w);
    send_payload(31, -1);
    announce(5);
    repeat (6) begin
      @(negedge clk);
      check("t2_wait_busy", busy, 1);
      check("t2_withheld", bus.proceed, 0);
    end
    check("t2_head", {bus.out_sop, bus.out_eop, bus.out_data}, 10'h240);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) pkt[i] = 8'(8'h80 + i);
    wait_grant(20, w);
    send_payload(5, -1);
    drain(100);
    check("t2_beats", n_out - base, 36);

    // Protocol error: announce during RECV of a 6-byte packet
    base = n_out;
    for (int i = 0; i < 6; i++) pkt[i] = 8'(8'h60 + i);
    announce(6);
    wait_grant(20, w);
    send_payload(6, 2);
    granted = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.proceed) granted++;
    end
    check("t3_no_grant", granted, 0);
    check("t3_idle", busy, 0);
    @(posedge clk); #1;
    drain(50);
    check("t3_beats", n_out - base, 6);
    check("t3_len_err_count", n_lenerr, 1);

    // Five back-to-back single-byte packets
    do_reset();
    bus.out_ready = 1'b0;
    base = n_out;
    for (int k = 0; k < 5; k++) begin
      pkt[0] = 8'(8'h10 + k);
      announce(1);
      wait_grant(20, w);
      check("t4_grant_latency", w, 2);
      send_payload(1, -1);
    end
    check("t4_head", {bus.out_sop, bus.out_eop, bus.out_data}, 10'h310);
    check("t4_pkt_cnt", pkt_cnt, STATS ? 5 : 0);
    drain(50);
    check("t4_beats", n_out - base, 5);

    // Reset after 2 of 8 bytes
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h70 + i);
    announce(8);
    wait_grant(20, w);
    for (int i = 0; i < 2; i++) begin
      bus.data_in = pkt[i];
      @(posedge clk); #1;
    end
    check("t5_pre_valid", bus.out_valid, 1);
    check("t5_pre_busy", busy, 1);
    #2;
    rst_b = 1'b1;
    exp_q.delete();
    model_pkts = 0;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_proceed", bus.proceed, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_pkt_cnt", pkt_cnt, 0);
    check("t5_rst_data", bus.out_data, 0);
    @(posedge clk); #3;
    rst_b = 1'b0;
    bus.data_in = '0;
    @(posedge clk); #1;
    base = n_out;
    bus.out_ready = 1'b1;
    pkt[0] = 8'h55; pkt[1] = 8'h66;
    announce(2);
    wait_grant(20, w);
    check("t5_grant_latency", w, 2);
    send_payload(2, -1);
    drain(50);
    check("t5_beats", n_out - base, 2);
    check("t5_pkt_cnt", pkt_cnt, STATS ? 1 : 0);
    check("final_len_err_count", n_lenerr, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
